// File: rtl/match_config_loader_pkg.sv
// Shared opcode/state encodings and width helpers for the CFG stream loader.
package match_config_loader_pkg;

   typedef enum logic [1:0] {
      OP_WRITE      = 2'b00,
      OP_INVALIDATE = 2'b01,
      OP_CLEAR_ALL  = 2'b10,
      OP_RESERVED   = 2'b11
   } cfg_op_t;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } ld_state_t;

   function automatic int tsel_width(input int tables);
      return (tables > 1) ? $clog2(tables) : 1;
   endfunction

endpackage

// File: rtl/match_config_loader_bitmap.sv
// Flat entry-valid bitmap; returns the prior state of the addressed bit so the
// caller can derive the occupancy delta in the same cycle it commits the update.
module match_config_loader_bitmap #(
   parameter int DEPTH = 256,
   parameter int IDX_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             set_bit,
   input  logic             clr_bit,
   input  logic             clear_all,
   input  logic [IDX_W-1:0] idx,
   output logic             old_bit
);

   logic [DEPTH-1:0] bits;

   assign old_bit = bits[idx];

   always_ff @(posedge clk) begin
      if (rst || clear_all) begin
         bits <= '0;
      end else if (set_bit) begin
         bits[idx] <= 1'b1;
      end else if (clr_bit) begin
         bits[idx] <= 1'b0;
      end
   end

endmodule

// File: rtl/match_config_loader.sv
// CFG stream receiver: decodes command words into hash-table row writes, runs the
// bulk-clear sweep, and tracks valid-rule occupancy and rejected-command counts.
module match_config_loader
   import match_config_loader_pkg::*;
#(
   parameter int KEY_WIDTH    = 128,
   parameter int RULE_WIDTH   = 16,
   parameter int TABLES       = 4,
   parameter int TABLE_SIZE   = 64,
   localparam int TSEL_W       = tsel_width(TABLES),
   localparam int ADDR_W       = $clog2(TABLE_SIZE),
   localparam int CNT_W        = $clog2(TABLES*TABLE_SIZE+1),
   localparam int CONFIG_WIDTH = 2+TSEL_W+ADDR_W+KEY_WIDTH+RULE_WIDTH,
   localparam int ENTRY_W      = 1+KEY_WIDTH+RULE_WIDTH
) (
   input  logic                    CLK,
   input  logic                    RESET,
   input  logic [CONFIG_WIDTH-1:0] CFG_DATA,
   input  logic                    CFG_VALID,
   output logic                    CFG_READY,
   output logic [TABLES-1:0]       TBL_WE,
   output logic [ADDR_W-1:0]       TBL_ADDR,
   output logic [ENTRY_W-1:0]      TBL_WDATA,
   output logic                    BUSY,
   output logic [CNT_W-1:0]        RULE_COUNT,
   output logic [15:0]             ERR_COUNT
);

   localparam int BM_DEPTH = TABLES*TABLE_SIZE;
   localparam int BM_W     = $clog2(BM_DEPTH);

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   cfg_op_t                 opcode;
   logic [TSEL_W-1:0]       tsel;
   logic [ADDR_W-1:0]       addr;
   logic [KEY_WIDTH-1:0]    key;
   logic [RULE_WIDTH-1:0]   rule;

   assign opcode = cfg_op_t'(CFG_DATA[CONFIG_WIDTH-1 -: 2]);
   assign tsel   = CFG_DATA[RULE_WIDTH+KEY_WIDTH+ADDR_W +: TSEL_W];
   assign addr   = CFG_DATA[RULE_WIDTH+KEY_WIDTH +: ADDR_W];
   assign key    = CFG_DATA[RULE_WIDTH +: KEY_WIDTH];
   assign rule   = CFG_DATA[RULE_WIDTH-1:0];

   ld_state_t               state, state_next;
   logic                    ready_p1, busy_p1;
   logic [TABLES-1:0]       we_p1;
   logic [ADDR_W-1:0]       addr_p1, sweep;
   logic [ENTRY_W-1:0]      wdata_p1;
   logic [CNT_W-1:0]        rule_cnt;
   logic [15:0]             err_cnt;
   logic                    bm_vld_p1, bm_set_p1, bm_old;
   logic [BM_W-1:0]         bm_idx_p1;

   logic                    xfer, tsel_ok;
   logic [TABLES-1:0]       tsel_dec;
   logic                    ready_d, busy_d, err_inc, clear_done, bm_vld_d, bm_set_d;
   logic [TABLES-1:0]       we_d;
   logic [ADDR_W-1:0]       addr_d, sweep_d;
   logic [ENTRY_W-1:0]      wdata_d;

   assign xfer    = CFG_VALID & ready_p1;
   assign tsel_ok = int'(tsel) < TABLES;

   always_comb begin
      tsel_dec = '0;
      for (int i = 0; i < TABLES; i++) tsel_dec[i] = (int'(tsel) == i);
   end

   // p0: decode the accepted word / advance the sweep
   always_comb begin
      state_next = state;
      ready_d    = 1'b1;
      busy_d     = 1'b0;
      we_d       = '0;
      addr_d     = addr_p1;
      wdata_d    = '0;
      sweep_d    = sweep;
      err_inc    = 1'b0;
      clear_done = 1'b0;
      bm_vld_d   = 1'b0;
      bm_set_d   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (xfer) begin
               case (opcode)
                  OP_WRITE, OP_INVALIDATE: begin
                     if (tsel_ok) begin
                        we_d     = tsel_dec;
                        addr_d   = addr;
                        bm_vld_d = 1'b1;
                        bm_set_d = (opcode == OP_WRITE);
                        if (opcode == OP_WRITE) wdata_d = {1'b1, key, rule};
                     end else begin
                        err_inc = 1'b1;
                     end
                  end
                  OP_CLEAR_ALL: begin
                     state_next = ST_CLEAR;
                     ready_d    = 1'b0;
                     busy_d     = 1'b1;
                     we_d       = '1;
                     addr_d     = '0;
                     sweep_d    = '0;
                  end
                  default: err_inc = 1'b1;
               endcase
            end
         end
         ST_CLEAR: begin
            if (sweep == ADDR_W'(TABLE_SIZE-1)) begin
               state_next = ST_IDLE;
               clear_done = 1'b1;
               addr_d     = '0;
               sweep_d    = '0;
            end else begin
               ready_d = 1'b0;
               busy_d  = 1'b1;
               we_d    = '1;
               addr_d  = sweep + ADDR_W'(1);
               sweep_d = sweep + ADDR_W'(1);
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) state <= ST_IDLE;
      else       state <= state_next;
   end

   // p1: registered table-write outputs; bitmap/count commit one cycle later
   always_ff @(posedge CLK) begin
      if (RESET) begin
         ready_p1  <= 1'b0;
         busy_p1   <= 1'b0;
         we_p1     <= '0;
         addr_p1   <= '0;
         wdata_p1  <= '0;
         sweep     <= '0;
         bm_vld_p1 <= 1'b0;
         bm_set_p1 <= 1'b0;
         rule_cnt  <= '0;
         err_cnt   <= '0;
      end else begin
         ready_p1  <= ready_d;
         busy_p1   <= busy_d;
         we_p1     <= we_d;
         addr_p1   <= addr_d;
         wdata_p1  <= wdata_d;
         sweep     <= sweep_d;
         bm_vld_p1 <= bm_vld_d;
         bm_set_p1 <= bm_set_d;
         if (clear_done)
            rule_cnt <= '0;
         else if (bm_vld_p1 && bm_set_p1 && !bm_old)
            rule_cnt <= rule_cnt + CNT_W'(1);
         else if (bm_vld_p1 && !bm_set_p1 && bm_old)
            rule_cnt <= rule_cnt - CNT_W'(1);
         if (err_inc) err_cnt <= sat_inc(err_cnt);
      end
      bm_idx_p1 <= BM_W'({tsel, addr});
   end

   match_config_loader_bitmap #(
      .DEPTH(BM_DEPTH),
      .IDX_W(BM_W)
   ) u_bitmap (
      .clk      (CLK),
      .rst      (RESET),
      .set_bit  (bm_vld_p1 & bm_set_p1),
      .clr_bit  (bm_vld_p1 & ~bm_set_p1),
      .clear_all(clear_done),
      .idx      (bm_idx_p1),
      .old_bit  (bm_old)
   );

   assign CFG_READY  = ready_p1;
   assign BUSY       = busy_p1;
   assign TBL_WE     = we_p1;
   assign TBL_ADDR   = addr_p1;
   assign TBL_WDATA  = wdata_p1;
   assign RULE_COUNT = rule_cnt;
   assign ERR_COUNT  = err_cnt;

endmodule

// File: tb/tb_match_config_loader.sv
// Randomized bench for match_config_loader against a row-level occupancy model.
module tb_match_config_loader;

   localparam int AK = 128, AR = 16, AT = 4, AS = 64;
   localparam int A_CW = 2+2+6+AK+AR, A_EW = 1+AK+AR;
   localparam int BK = 8, BR = 8, BT = 3, BS = 4;
   localparam int B_CW = 2+2+2+BK+BR, B_EW = 1+BK+BR;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic a_rst, a_valid, a_ready, a_busy;
   logic [A_CW-1:0] a_data;
   logic [3:0] a_we;
   logic [5:0] a_addr;
   logic [A_EW-1:0] a_wdata;
   logic [8:0] a_cnt;
   logic [15:0] a_err;

   logic b_rst, b_valid, b_ready, b_busy;
   logic [B_CW-1:0] b_data;
   logic [2:0] b_we;
   logic [1:0] b_addr;
   logic [B_EW-1:0] b_wdata;
   logic [3:0] b_cnt;
   logic [15:0] b_err;

   match_config_loader #(.KEY_WIDTH(AK), .RULE_WIDTH(AR), .TABLES(AT), .TABLE_SIZE(AS)) dut_a (
      .CLK(clk), .RESET(a_rst), .CFG_DATA(a_data), .CFG_VALID(a_valid), .CFG_READY(a_ready),
      .TBL_WE(a_we), .TBL_ADDR(a_addr), .TBL_WDATA(a_wdata), .BUSY(a_busy),
      .RULE_COUNT(a_cnt), .ERR_COUNT(a_err));

   match_config_loader #(.KEY_WIDTH(BK), .RULE_WIDTH(BR), .TABLES(BT), .TABLE_SIZE(BS)) dut_b (
      .CLK(clk), .RESET(b_rst), .CFG_DATA(b_data), .CFG_VALID(b_valid), .CFG_READY(b_ready),
      .TBL_WE(b_we), .TBL_ADDR(b_addr), .TBL_WDATA(b_wdata), .BUSY(b_busy),
      .RULE_COUNT(b_cnt), .ERR_COUNT(b_err));

   int errors = 0;
   int checks = 0;
   bit model_v [AT][AS];

   function automatic int model_count();
      int n = 0;
      for (int t = 0; t < AT; t++)
         for (int a = 0; a < AS; a++) n += int'(model_v[t][a]);
      return n;
   endfunction

   function automatic void model_clear();
      for (int t = 0; t < AT; t++)
         for (int a = 0; a < AS; a++) model_v[t][a] = 1'b0;
   endfunction

   function automatic logic [AK-1:0] rand_key();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   function automatic logic [A_CW-1:0] pack_a(input logic [1:0] op, input int t, input int ad,
                                              input logic [AK-1:0] k, input logic [AR-1:0] r);
      logic [1:0] ts = t[1:0];
      logic [5:0] aa = ad[5:0];
      return {op, ts, aa, k, r};
   endfunction

   function automatic logic [B_CW-1:0] pack_b(input logic [1:0] op, input int t, input int ad,
                                              input logic [BK-1:0] k, input logic [BR-1:0] r);
      logic [1:0] ts = t[1:0];
      logic [1:0] aa = ad[1:0];
      return {op, ts, aa, k, r};
   endfunction

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_a(input logic [1:0] op, input int t, input int ad,
                         input logic [AK-1:0] k, input logic [AR-1:0] r);
      a_data  = pack_a(op, t, ad, k, r);
      a_valid = 1'b1;
      tick(1);
      a_valid = 1'b0;
   endtask

   task automatic send_b(input logic [1:0] op, input int t, input int ad);
      b_data  = pack_b(op, t, ad, BK'($urandom), BR'($urandom));
      b_valid = 1'b1;
      tick(1);
      b_valid = 1'b0;
   endtask

   task automatic test_reset();
      a_rst = 1'b1; b_rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0;
      a_data = '0; b_data = '0;
      tick(3);
      checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL rst_ready_hi got=%b exp=0", a_ready); end
      a_rst = 1'b0; b_rst = 1'b0;
      tick(1);
      checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got=%b exp=1", a_ready); end
      checks++; if (b_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_b got=%b exp=1", b_ready); end
      checks++; if (a_we !== 4'h0 || a_addr !== 6'd0 || a_wdata !== '0)
         begin errors++; $display("FAIL rst_tbl got we=%h addr=%0d wdata=%h exp zeros", a_we, a_addr, a_wdata); end
      checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", a_busy); end
      checks++; if (a_cnt !== 9'd0 || a_err !== 16'd0)
         begin errors++; $display("FAIL rst_counts got rc=%0d ec=%0d exp 0 0", a_cnt, a_err); end
      model_clear();
   endtask

   task automatic test_write_single();
      logic [AK-1:0] k = rand_key();
      send_a(2'b00, 2, 5, k, 16'd7);
      model_v[2][5] = 1'b1;
      checks++; if (a_we !== 4'b0100 || a_addr !== 6'd5)
         begin errors++; $display("FAIL wr1_we_addr got we=%b addr=%0d exp we=0100 addr=5", a_we, a_addr); end
      checks++; if (a_wdata !== {1'b1, k, 16'd7})
         begin errors++; $display("FAIL wr1_wdata got=%h exp=%h", a_wdata, {1'b1, k, 16'd7}); end
      tick(1);
      checks++; if (a_we !== 4'h0) begin errors++; $display("FAIL wr1_we_drop got=%b exp=0000", a_we); end
      checks++; if (a_cnt !== 9'(model_count()))
         begin errors++; $display("FAIL wr1_count got=%0d exp=%0d", a_cnt, model_count()); end
   endtask

   task automatic test_back_to_back();
      int perm [256];
      int j, tmp, t, ad, exp_cnt;
      logic [AK-1:0] k;
      logic [AR-1:0] r;
      logic [3:0] exp_we;
      for (int i = 0; i < 256; i++) perm[i] = i;
      for (int i = 255; i > 0; i--) begin
         j = $urandom_range(i, 0); tmp = perm[i]; perm[i] = perm[j]; perm[j] = tmp;
      end
      for (int i = 0; i < 256; i++) begin
         t = perm[i] / AS; ad = perm[i] % AS; k = rand_key(); r = AR'($urandom);
         checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready word=%0d got=%b exp=1", i, a_ready); end
         a_data = pack_a(2'b00, t, ad, k, r);
         a_valid = 1'b1;
         tick(1);
         exp_cnt = model_count();
         exp_we = 4'b0001 << t;
         checks++; if (a_we !== exp_we || a_addr !== ad[5:0] || a_wdata !== {1'b1, k, r})
            begin errors++; $display("FAIL b2b_write word=%0d got we=%b addr=%0d exp we=%b addr=%0d", i, a_we, a_addr, exp_we, ad); end
         checks++; if (a_cnt !== 9'(exp_cnt))
            begin errors++; $display("FAIL b2b_count word=%0d got=%0d exp=%0d", i, a_cnt, exp_cnt); end
         model_v[t][ad] = 1'b1;
      end
      a_valid = 1'b0;
      tick(1);
      checks++; if (a_cnt !== 9'(model_count()))
         begin errors++; $display("FAIL b2b_full got=%0d exp=%0d", a_cnt, model_count()); end
      send_a(2'b00, perm[0] / AS, perm[0] % AS, rand_key(), AR'($urandom));
      tick(1);
      checks++; if (a_cnt !== 9'(model_count()))
         begin errors++; $display("FAIL b2b_overwrite got=%0d exp=%0d", a_cnt, model_count()); end
   endtask

   task automatic test_invalidate();
      int t = $urandom_range(AT-1, 0);
      int ad = $urandom_range(AS-1, 0);
      logic [3:0] exp_we = 4'b0001 << t;
      for (int rep = 0; rep < 2; rep++) begin
         send_a(2'b01, t, ad, rand_key(), AR'($urandom));
         model_v[t][ad] = 1'b0;
         checks++; if (a_we !== exp_we || a_addr !== 6'(ad) || a_wdata !== '0)
            begin errors++; $display("FAIL inv_write rep=%0d got we=%b addr=%0d wdata=%h exp we=%b addr=%0d wdata=0", rep, a_we, a_addr, a_wdata, exp_we, ad); end
         tick(1);
         checks++; if (a_cnt !== 9'(model_count()))
            begin errors++; $display("FAIL inv_count rep=%0d got=%0d exp=%0d", rep, a_cnt, model_count()); end
      end
   endtask

   task automatic test_clear();
      int t = $urandom_range(AT-1, 0), ad = $urandom_range(AS-1, 0);
      int t2 = $urandom_range(AT-1, 0), ad2 = $urandom_range(AS-1, 0);
      logic [3:0] exp_we = 4'b0001 << t2;
      a_data = pack_a(2'b00, t, ad, rand_key(), AR'($urandom));
      a_valid = 1'b1;
      tick(1);
      model_v[t][ad] = 1'b1;
      a_data = pack_a(2'b10, t2, ad2, rand_key(), AR'($urandom));
      tick(1);
      a_data = pack_a(2'b00, t2, ad2, rand_key(), AR'($urandom));
      checks++; if (a_cnt !== 9'(model_count()))
         begin errors++; $display("FAIL clr_prewrite got=%0d exp=%0d", a_cnt, model_count()); end
      model_clear();
      for (int r = 0; r < AS; r++) begin
         checks++; if (a_we !== 4'hF || a_addr !== 6'(r) || a_wdata !== '0 || a_busy !== 1'b1 || a_ready !== 1'b0)
            begin errors++; $display("FAIL clr_row r=%0d got we=%h addr=%0d busy=%b ready=%b exp we=f addr=%0d busy=1 ready=0", r, a_we, a_addr, a_busy, a_ready, r); end
         tick(1);
      end
      checks++; if (a_ready !== 1'b1 || a_busy !== 1'b0)
         begin errors++; $display("FAIL clr_exit got ready=%b busy=%b exp 1 0", a_ready, a_busy); end
      checks++; if (a_we !== 4'h0) begin errors++; $display("FAIL clr_we_exit got=%h exp=0", a_we); end
      checks++; if (a_cnt !== 9'(model_count()))
         begin errors++; $display("FAIL clr_count got=%0d exp=%0d", a_cnt, model_count()); end
      tick(1);
      a_valid = 1'b0;
      model_v[t2][ad2] = 1'b1;
      checks++; if (a_we !== exp_we || a_addr !== 6'(ad2))
         begin errors++; $display("FAIL clr_next_xfer got we=%b addr=%0d exp we=%b addr=%0d", a_we, a_addr, exp_we, ad2); end
      tick(1);
      checks++; if (a_cnt !== 9'(model_count()))
         begin errors++; $display("FAIL clr_next_count got=%0d exp=%0d", a_cnt, model_count()); end
   endtask

   task automatic test_errors_a();
      int exp_err = 0;
      int cnt0 = model_count();
      for (int rep = 0; rep < 2; rep++) begin
         send_a(2'b11, $urandom_range(AT-1, 0), $urandom_range(AS-1, 0), rand_key(), AR'($urandom));
         exp_err++;
         checks++; if (a_we !== 4'h0) begin errors++; $display("FAIL err_we rep=%0d got=%h exp=0", rep, a_we); end
         tick(1);
         checks++; if (a_err !== 16'(exp_err) || a_cnt !== 9'(cnt0))
            begin errors++; $display("FAIL err_count rep=%0d got ec=%0d rc=%0d exp ec=%0d rc=%0d", rep, a_err, a_cnt, exp_err, cnt0); end
      end
   endtask

   task automatic test_reset_mid_clear();
      for (int i = 0; i < 3; i++) begin
         send_a(2'b00, $urandom_range(AT-1, 0), $urandom_range(AS-1, 0), rand_key(), AR'($urandom));
      end
      send_a(2'b10, 0, 0, rand_key(), AR'($urandom));
      tick(20);
      checks++; if (a_addr !== 6'd20 || a_busy !== 1'b1)
         begin errors++; $display("FAIL rmc_row got addr=%0d busy=%b exp addr=20 busy=1", a_addr, a_busy); end
      a_rst = 1'b1;
      tick(1);
      model_clear();
      checks++; if (a_busy !== 1'b0 || a_we !== 4'h0 || a_ready !== 1'b0)
         begin errors++; $display("FAIL rmc_abort got busy=%b we=%h ready=%b exp 0 0 0", a_busy, a_we, a_ready); end
      checks++; if (a_cnt !== 9'd0 || a_err !== 16'd0)
         begin errors++; $display("FAIL rmc_counts got rc=%0d ec=%0d exp 0 0", a_cnt, a_err); end
      a_rst = 1'b0;
      tick(1);
      checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL rmc_ready got=%b exp=1", a_ready); end
   endtask

   task automatic test_errors_b();
      int exp_err = 0;
      bit we_seen = 1'b0;
      send_b(2'b00, 2, 3);
      checks++; if (b_we !== 3'b100 || b_addr !== 2'd3)
         begin errors++; $display("FAIL b_write got we=%b addr=%0d exp we=100 addr=3", b_we, b_addr); end
      tick(1);
      checks++; if (b_cnt !== 4'd1) begin errors++; $display("FAIL b_count got=%0d exp=1", b_cnt); end
      send_b(2'b00, 3, $urandom_range(BS-1, 0));
      exp_err++;
      checks++; if (b_we !== 3'b000) begin errors++; $display("FAIL b_tsel_wr_we got=%b exp=000", b_we); end
      send_b(2'b01, 3, $urandom_range(BS-1, 0));
      exp_err++;
      checks++; if (b_we !== 3'b000) begin errors++; $display("FAIL b_tsel_inv_we got=%b exp=000", b_we); end
      tick(1);
      checks++; if (b_err !== 16'(exp_err) || b_cnt !== 4'd1)
         begin errors++; $display("FAIL b_tsel_err got ec=%0d rc=%0d exp ec=%0d rc=1", b_err, b_cnt, exp_err); end
      b_data = pack_b(2'b11, $urandom_range(3, 0), $urandom_range(3, 0), BK'($urandom), BR'($urandom));
      b_valid = 1'b1;
      repeat (65535 - 1 - exp_err) begin
         tick(1);
         if (b_we !== 3'b000) we_seen = 1'b1;
      end
      exp_err = 65534;
      checks++; if (b_err !== 16'(exp_err))
         begin errors++; $display("FAIL b_sat_pre got=%0d exp=%0d", b_err, exp_err); end
      tick(1);
      checks++; if (b_err !== 16'hFFFF) begin errors++; $display("FAIL b_sat_hit got=%h exp=ffff", b_err); end
      repeat (5) begin
         tick(1);
         if (b_we !== 3'b000) we_seen = 1'b1;
      end
      b_valid = 1'b0;
      checks++; if (b_err !== 16'hFFFF) begin errors++; $display("FAIL b_sat_hold got=%h exp=ffff", b_err); end
      checks++; if (we_seen !== 1'b0 || b_cnt !== 4'd1)
         begin errors++; $display("FAIL b_sat_side got we_seen=%b rc=%0d exp 0 1", we_seen, b_cnt); end
   endtask

   initial begin
      test_reset();
      test_write_single();
      test_back_to_back();
      test_invalidate();
      test_clear();
      test_errors_a();
      test_reset_mid_clear();
      test_errors_b();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
